// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, instruction field positions and
// operand-use helpers for the ID stage.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned RS_MSB     = 25;
   localparam int unsigned RS_LSB     = 21;
   localparam int unsigned RT_MSB     = 20;
   localparam int unsigned RT_LSB     = 16;
   localparam int unsigned RD_MSB     = 15;
   localparam int unsigned RD_LSB     = 11;
   localparam int unsigned FUNCT_MSB  = 5;
   localparam int unsigned FUNCT_LSB  = 0;
   localparam int unsigned IMM_MSB    = 15;
   localparam int unsigned IMM_LSB    = 0;

   // True when the instruction reads rt as a source operand (not as a destination).
   function automatic logic reads_rt(input logic [5:0] opcode);
      return opcode inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decoded-instruction bundle from the ID stage to the ID/EX register.
interface decode_stage_if #(
   parameter int unsigned DATA_W = 32
);
   logic              id_valid;
   logic [31:0]       id_pc4;
   logic [DATA_W-1:0] id_rs_data;
   logic [DATA_W-1:0] id_rt_data;
   logic [31:0]       id_imm;
   logic [31:0]       id_branch_target;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic [4:0]        id_rd;
   logic [5:0]        id_opcode;
   logic [5:0]        id_funct;

   modport master (
      output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_branch_target,
             id_rs, id_rt, id_rd, id_opcode, id_funct
   );

   modport slave (
      input id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_branch_target,
            id_rs, id_rt, id_rd, id_opcode, id_funct
   );
endinterface

// File: rtl/RegFile.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one synchronous write port; register 0 is hardwired to zero.
module RegFile #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_COUNT = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        i_ra,
   input  logic [4:0]        i_rb,
   output logic [DATA_W-1:0] o_rda,
   output logic [DATA_W-1:0] o_rdb,
   input  logic              i_we,
   input  logic [4:0]        i_wa,
   input  logic [DATA_W-1:0] i_wd
);

   logic [DATA_W-1:0] r_regs [REG_COUNT];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_wa != 5'd0)) begin
         r_regs[i_wa] <= i_wd;
      end
   end

   // Bypass lets an instruction in ID see the value being written back this cycle.
   always_comb begin
      o_rda = r_regs[i_ra];
      if (i_ra == 5'd0) begin
         o_rda = '0;
      end else if (i_we && (i_wa == i_ra)) begin
         o_rda = i_wd;
      end
   end

   always_comb begin
      o_rdb = r_regs[i_rb];
      if (i_rb == 5'd0) begin
         o_rdb = '0;
      end else if (i_we && (i_wa == i_rb)) begin
         o_rdb = i_wd;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction decode stage: IF/ID pipeline register, load-use hazard
// detection with one-cycle stall, field decode and register-file read.
module decode_stage
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_COUNT = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       inst,
   input  logic [31:0]       ifOut,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_mem_read,
   input  logic [4:0]        ex_rt,
   output logic              PCWrite,
   decode_stage_if.master    o_id
);

   logic [31:0]       r_instr;
   logic [31:0]       r_pc4;
   logic              r_valid;

   logic [5:0]        w_opcode;
   logic [4:0]        w_rs;
   logic [4:0]        w_rt;
   logic [4:0]        w_rd;
   logic [5:0]        w_funct;
   logic [31:0]       w_imm;
   logic              w_hazard;
   logic [DATA_W-1:0] w_rs_data;
   logic [DATA_W-1:0] w_rt_data;

   assign w_opcode = r_instr[OPCODE_MSB:OPCODE_LSB];
   assign w_rs     = r_instr[RS_MSB:RS_LSB];
   assign w_rt     = r_instr[RT_MSB:RT_LSB];
   assign w_rd     = r_instr[RD_MSB:RD_LSB];
   assign w_funct  = r_instr[FUNCT_MSB:FUNCT_LSB];
   assign w_imm    = {{16{r_instr[IMM_MSB]}}, r_instr[IMM_MSB:IMM_LSB]};

   // Load-use: the load in EX targets a register this instruction reads.
   assign w_hazard = ex_mem_read && (ex_rt != 5'd0) && r_valid &&
                     ((ex_rt == w_rs) || ((ex_rt == w_rt) && reads_rt(w_opcode)));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_instr <= '0;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (flush) begin
         r_instr <= '0;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (!w_hazard) begin
         r_instr <= inst;
         r_pc4   <= ifOut;
         r_valid <= 1'b1;
      end
   end

   RegFile #(
      .DATA_W    (DATA_W),
      .REG_COUNT (REG_COUNT)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .i_ra  (w_rs),
      .i_rb  (w_rt),
      .o_rda (w_rs_data),
      .o_rdb (w_rt_data),
      .i_we  (wb_en),
      .i_wa  (wb_addr),
      .i_wd  (wb_data)
   );

   assign PCWrite = ~w_hazard;

   assign o_id.id_valid         = r_valid & ~w_hazard;
   assign o_id.id_pc4           = r_pc4;
   assign o_id.id_rs_data       = w_rs_data;
   assign o_id.id_rt_data       = w_rt_data;
   assign o_id.id_imm           = w_imm;
   assign o_id.id_branch_target = r_pc4 + {w_imm[29:0], 2'b00};
   assign o_id.id_rs            = w_rs;
   assign o_id.id_rt            = w_rt;
   assign o_id.id_rd            = w_rd;
   assign o_id.id_opcode        = w_opcode;
   assign o_id.id_funct         = w_funct;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table followed by
// randomized traffic compared against a behavioural model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inst;
   logic [31:0] ifOut;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_mem_read;
   logic [4:0]  ex_rt;
   logic        PCWrite;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_stage_if #(.DATA_W(32)) dif ();

   decode_stage u_dut (
      .clk         (clk),
      .reset       (reset),
      .inst        (inst),
      .ifOut       (ifOut),
      .flush       (flush),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .PCWrite     (PCWrite),
      .o_id        (dif)
   );

   // Behavioural model of the architectural state.
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic [31:0] m_regs [32];

   typedef struct {
      logic        rst;
      logic        fl;
      logic [31:0] in;
      logic [31:0] pc;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        mr;
      logic [4:0]  xr;
      logic        e_pcw;
      logic        e_vld;
      logic [5:0]  e_op;
      logic [4:0]  e_rs;
      logic [4:0]  e_rt;
      logic [31:0] e_imm;
      logic [31:0] e_bt;
      logic [31:0] e_rsd;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mk(input logic rst, input logic fl, input logic [31:0] in,
                               input logic [31:0] pc, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic mr, input logic [4:0] xr,
                               input logic pcw, input logic vld, input logic [5:0] op,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [31:0] imm, input logic [31:0] bt,
                               input logic [31:0] rsd);
      vec_t v;
      v.rst = rst;  v.fl = fl;   v.in = in;   v.pc = pc;   v.we = we;
      v.wa = wa;    v.wd = wd;   v.mr = mr;   v.xr = xr;   v.e_pcw = pcw;
      v.e_vld = vld; v.e_op = op; v.e_rs = rs; v.e_rt = rt; v.e_imm = imm;
      v.e_bt = bt;  v.e_rsd = rsd;
      return v;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (wb_en && wb_addr == idx) return wb_data;
      return m_regs[idx];
   endfunction

   function automatic logic model_hazard();
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       rt_src;
      op = 6'((m_instr >> 26) & 32'h3F);
      rs = 5'((m_instr >> 21) & 32'h1F);
      rt = 5'((m_instr >> 16) & 32'h1F);
      rt_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
      return ex_mem_read && ex_rt != 0 && m_valid && (ex_rt == rs || (ex_rt == rt && rt_src));
   endfunction

   task automatic model_update();
      logic hz;
      hz = model_hazard();
      if (!reset) begin
         m_instr = 0;
         m_pc4   = 0;
         m_valid = 0;
         for (int i = 0; i < 32; i++) m_regs[i] = 0;
      end else begin
         if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
         if (flush) begin
            m_instr = 0;
            m_pc4   = 0;
            m_valid = 0;
         end else if (!hz) begin
            m_instr = inst;
            m_pc4   = ifOut;
            m_valid = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic apply(input vec_t v);
      reset = v.rst;  flush = v.fl;  inst = v.in;  ifOut = v.pc;
      wb_en = v.we;   wb_addr = v.wa; wb_data = v.wd;
      ex_mem_read = v.mr; ex_rt = v.xr;
   endtask

   task automatic check_row(input int idx, input vec_t v);
      logic [113:0] got;
      logic [113:0] exp;
      got = {PCWrite, dif.id_valid, dif.id_opcode, dif.id_rs, dif.id_rt, dif.id_imm,
             dif.id_branch_target, dif.id_rs_data};
      exp = {v.e_pcw, v.e_vld, v.e_op, v.e_rs, v.e_rt, v.e_imm, v.e_bt, v.e_rsd};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL vec%0d: got %h expected %h", idx, got, exp);
      end
   endtask

   task automatic check_model(input string name);
      logic [188:0] got;
      logic [188:0] exp;
      logic         hz;
      logic [31:0]  imm;
      hz  = model_hazard();
      imm = 32'($signed(m_instr[15:0]));
      got = {PCWrite, dif.id_valid, dif.id_opcode, dif.id_rs, dif.id_rt, dif.id_rd,
             dif.id_funct, dif.id_pc4, dif.id_rs_data, dif.id_rt_data, dif.id_imm,
             dif.id_branch_target};
      exp = {!hz, m_valid && !hz, 6'(m_instr >> 26), 5'(m_instr >> 21), 5'(m_instr >> 16),
             5'(m_instr >> 11), 6'(m_instr), m_pc4,
             model_read(5'(m_instr >> 21)), model_read(5'(m_instr >> 16)),
             imm, m_pc4 + imm * 32'd4};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   initial begin
      logic [5:0] ops [6];
      ops[0] = 6'h00; ops[1] = 6'h04; ops[2] = 6'h05;
      ops[3] = 6'h2B; ops[4] = 6'h23; ops[5] = 6'h08;

      //          rst fl inst          ifOut  we wa    wd            mr xr    pcw vld op     rs     rt     imm           bt            rs_data
      tbl[0]  = mk(0, 0, 32'h0,        32'h0,  0, 5'd0, 32'h0,        0, 5'd0, 1, 0, 6'h00, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0);
      tbl[1]  = mk(1, 0, 32'h8C220004, 32'h8,  0, 5'd0, 32'h0,        0, 5'd0, 1, 0, 6'h00, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0);
      tbl[2]  = mk(1, 0, 32'h00441820, 32'hC,  0, 5'd0, 32'h0,        0, 5'd0, 1, 1, 6'h23, 5'd1, 5'd2, 32'h4,        32'h18,       32'h0);
      tbl[3]  = mk(1, 0, 32'h1085FFFF, 32'h10, 0, 5'd0, 32'h0,        1, 5'd2, 0, 0, 6'h00, 5'd2, 5'd4, 32'h1820,     32'h608C,     32'h0);
      tbl[4]  = mk(1, 0, 32'h1085FFFF, 32'h10, 0, 5'd0, 32'h0,        0, 5'd0, 1, 1, 6'h00, 5'd2, 5'd4, 32'h1820,     32'h608C,     32'h0);
      tbl[5]  = mk(1, 1, 32'h00A00000, 32'h14, 0, 5'd0, 32'h0,        1, 5'd5, 0, 0, 6'h04, 5'd4, 5'd5, 32'hFFFFFFFF, 32'hC,        32'h0);
      tbl[6]  = mk(1, 0, 32'h00A00000, 32'h14, 0, 5'd0, 32'h0,        1, 5'd5, 1, 0, 6'h00, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0);
      tbl[7]  = mk(1, 0, 32'h00A00000, 32'h18, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 1, 1, 6'h00, 5'd5, 5'd0, 32'h0,        32'h14,       32'hDEADBEEF);
      tbl[8]  = mk(1, 0, 32'h0000FFFF, 32'h0,  1, 5'd0, 32'h12345678, 0, 5'd0, 1, 1, 6'h00, 5'd5, 5'd0, 32'h0,        32'h18,       32'hDEADBEEF);
      tbl[9]  = mk(1, 0, 32'h00441820, 32'h4,  0, 5'd0, 32'h0,        1, 5'd0, 1, 1, 6'h00, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0);
      tbl[10] = mk(0, 0, 32'h00A00000, 32'h8,  0, 5'd0, 32'h0,        1, 5'd2, 0, 0, 6'h00, 5'd2, 5'd4, 32'h1820,     32'h6084,     32'h0);
      tbl[11] = mk(1, 0, 32'h00A00000, 32'h8,  0, 5'd0, 32'h0,        1, 5'd2, 1, 0, 6'h00, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0);
      tbl[12] = mk(1, 0, 32'h0,        32'h0,  0, 5'd0, 32'h0,        0, 5'd0, 1, 1, 6'h00, 5'd5, 5'd0, 32'h0,        32'h8,        32'h0);

      apply(tbl[0]);
      tick();
      tick();

      for (int i = 0; i < 13; i++) begin
         apply(tbl[i]);
         @(negedge clk);
         check_row(i, tbl[i]);
         tick();
      end

      for (int n = 0; n < 400; n++) begin
         reset       = ($urandom_range(0, 39) != 0);
         flush       = ($urandom_range(0, 7) == 0);
         inst        = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 16'($urandom)};
         ifOut       = $urandom;
         wb_en       = 1'($urandom);
         wb_addr     = 5'($urandom_range(0, 7));
         wb_data     = $urandom;
         ex_mem_read = 1'($urandom);
         ex_rt       = 5'($urandom_range(0, 7));
         @(negedge clk);
         check_model("rand");
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
